// File: rtl/gelato_fetch_arbiter.sv
// gelato_fetch_arbiter: shares one instruction-fetch port round-robin among
// active warps. Each warp may have at most one fetch outstanding until decode
// responds, and may only fetch while it holds ibuffer credits.
module gelato_fetch_arbiter #(
    parameter int NUM_WARPS  = 4,
    parameter int PC_WIDTH   = 32,
    parameter int IBUF_DEPTH = 4,
    localparam int WID = $clog2(NUM_WARPS),
    localparam int CW  = $clog2(IBUF_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic [NUM_WARPS-1:0]          warp_valid,
    input  logic [NUM_WARPS*PC_WIDTH-1:0] warp_pc,
    input  logic [NUM_WARPS-1:0]          ibuf_release,
    input  logic                          resp_valid,
    input  logic [WID-1:0]                resp_warp_id,
    output logic                          fetch_valid,
    input  logic                          fetch_ready,
    output logic [WID-1:0]                fetch_warp_id,
    output logic [PC_WIDTH-1:0]           fetch_pc,
    output logic                          credit_err
);

    // Registered state
    logic                          r_fetch_valid;
    logic [WID-1:0]                r_fetch_warp_id;
    logic [PC_WIDTH-1:0]           r_fetch_pc;
    logic                          r_credit_err;
    logic [NUM_WARPS-1:0][CW-1:0]  r_credits;
    logic [NUM_WARPS-1:0]          r_inflight;
    logic [WID-1:0]                r_rr_ptr;

    // Combinational helpers
    logic                          w_grant;
    logic                          w_load;
    logic [NUM_WARPS-1:0]          w_grant_vec;
    logic [NUM_WARPS-1:0]          w_resp_vec;
    logic [NUM_WARPS-1:0]          w_elig;
    logic                          w_found;
    logic [WID-1:0]                w_sel;
    logic [PC_WIDTH-1:0]           w_sel_pc;
    logic [NUM_WARPS-1:0][CW-1:0]  w_cred_nxt;
    logic [NUM_WARPS-1:0]          w_infl_nxt;
    logic                          w_rel_err;

    assign fetch_valid   = r_fetch_valid;
    assign fetch_warp_id = r_fetch_warp_id;
    assign fetch_pc      = r_fetch_pc;
    assign credit_err    = r_credit_err;

    // Decode grant/response per warp and derive eligibility; the warp being
    // granted now is excluded because its inflight bit is only just being set.
    always_comb begin
        w_grant     = rdy & r_fetch_valid & fetch_ready;
        w_load      = rdy & (~r_fetch_valid | fetch_ready);
        w_grant_vec = '0;
        w_resp_vec  = '0;
        w_elig      = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            w_grant_vec[i] = w_grant & (r_fetch_warp_id == WID'(i));
            w_resp_vec[i]  = resp_valid & (resp_warp_id == WID'(i));
            w_elig[i]      = warp_valid[i] & ~r_inflight[i] &
                             (r_credits[i] != '0) & ~w_grant_vec[i];
        end
    end

    // Round-robin search of eligible warps starting at the pointer, then PC mux.
    always_comb begin
        logic [WID-1:0] idx;
        idx      = '0;
        w_found  = 1'b0;
        w_sel    = r_rr_ptr;
        w_sel_pc = '0;
        for (int k = 0; k < NUM_WARPS; k++) begin
            idx = r_rr_ptr + WID'(k);
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_sel   = idx;
            end
        end
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (w_sel == WID'(i)) begin
                w_sel_pc = warp_pc[i*PC_WIDTH +: PC_WIDTH];
            end
        end
    end

    // Next credit and inflight values; a release and a grant on the same warp
    // cancel out, and a release into a full counter saturates and flags error.
    always_comb begin
        w_rel_err  = 1'b0;
        w_cred_nxt = r_credits;
        w_infl_nxt = r_inflight;
        for (int i = 0; i < NUM_WARPS; i++) begin
            w_infl_nxt[i] = w_grant_vec[i] | (r_inflight[i] & ~w_resp_vec[i]);
            if (ibuf_release[i] && !w_grant_vec[i]) begin
                if (r_credits[i] == CW'(IBUF_DEPTH)) begin
                    w_rel_err = 1'b1;
                end else begin
                    w_cred_nxt[i] = r_credits[i] + CW'(1);
                end
            end else if (w_grant_vec[i] && !ibuf_release[i]) begin
                w_cred_nxt[i] = r_credits[i] - CW'(1);
            end
        end
    end

    // State register: reset wins, rdy=0 freezes everything, otherwise update
    // bookkeeping and load a new request whenever the output slot is free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_valid   <= 1'b0;
            r_fetch_warp_id <= '0;
            r_fetch_pc      <= '0;
            r_credit_err    <= 1'b0;
            r_inflight      <= '0;
            r_rr_ptr        <= '0;
            for (int i = 0; i < NUM_WARPS; i++) begin
                r_credits[i] <= CW'(IBUF_DEPTH);
            end
        end else if (rdy) begin
            r_credits    <= w_cred_nxt;
            r_inflight   <= w_infl_nxt;
            r_credit_err <= r_credit_err | w_rel_err;
            if (w_load) begin
                if (w_found) begin
                    r_fetch_valid   <= 1'b1;
                    r_fetch_warp_id <= w_sel;
                    r_fetch_pc      <= w_sel_pc;
                    r_rr_ptr        <= w_sel + WID'(1);
                end else begin
                    r_fetch_valid   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gelato_fetch_arbiter.sv
// Testbench for gelato_fetch_arbiter: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a behavioural model.
module tb_gelato_fetch_arbiter;

    localparam int N  = 4;
    localparam int PW = 32;
    localparam int D  = 4;

    logic            clk;
    logic            rst;
    logic            rdy;
    logic [N-1:0]    warp_valid;
    logic [N*PW-1:0] warp_pc;
    logic [N-1:0]    ibuf_release;
    logic            resp_valid;
    logic [1:0]      resp_warp_id;
    logic            fetch_valid;
    logic            fetch_ready;
    logic [1:0]      fetch_warp_id;
    logic [PW-1:0]   fetch_pc;
    logic            credit_err;

    gelato_fetch_arbiter #(.NUM_WARPS(N), .PC_WIDTH(PW), .IBUF_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .warp_valid(warp_valid), .warp_pc(warp_pc),
        .ibuf_release(ibuf_release),
        .resp_valid(resp_valid), .resp_warp_id(resp_warp_id),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_warp_id(fetch_warp_id), .fetch_pc(fetch_pc),
        .credit_err(credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_cred[N];
    bit            m_infl[N];
    int            m_rr;
    bit            m_fv;
    int            m_fid;
    logic [PW-1:0] m_fpc;
    bit            m_err;

    typedef struct {int due; int w;} resp_t;
    resp_t rq[$];
    int    resp_delay;   // 0 selects a random delay
    int    cyc = 0;
    int    dcount[N];    // grants observed on the DUT ports

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock edge of the reference behaviour, using the inputs at the edge.
    task automatic model_step();
        bit     g;
        int     gw;
        bit     el[N];
        bit     found;
        int     w;
        int     d;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_cred[i] = D;
                m_infl[i] = 0;
            end
            m_rr = 0; m_fv = 0; m_fid = 0; m_fpc = '0; m_err = 0;
            return;
        end
        if (!rdy) return;
        g  = m_fv && fetch_ready;
        gw = m_fid;
        for (int i = 0; i < N; i++)
            el[i] = warp_valid[i] && !m_infl[i] && (m_cred[i] > 0) && !(g && gw == i);
        if (resp_valid) m_infl[int'(resp_warp_id)] = 0;
        if (g) begin
            m_infl[gw] = 1;
            d = (resp_delay == 0) ? int'($urandom_range(1, 5)) : resp_delay;
            rq.push_back('{due: cyc + d, w: gw});
        end
        for (int i = 0; i < N; i++) begin
            bit gi;
            gi = g && (gw == i);
            if (ibuf_release[i] && !gi) begin
                if (m_cred[i] == D) m_err = 1;
                else m_cred[i]++;
            end else if (gi && !ibuf_release[i]) begin
                m_cred[i]--;
            end
        end
        if (!m_fv || fetch_ready) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                w = (m_rr + k) % N;
                if (!found && el[w]) begin
                    found = 1;
                    m_fv  = 1;
                    m_fid = w;
                    m_fpc = warp_pc[w*PW +: PW];
                    m_rr  = (w + 1) % N;
                end
            end
            if (!found) m_fv = 0;
        end
    endtask

    // Advance one cycle, step the model and compare all outputs.
    task automatic tick();
        bit dg;
        int dw;
        dg = fetch_valid && fetch_ready && rdy && !rst;
        dw = int'(fetch_warp_id);
        @(posedge clk);
        cyc++;
        if (dg) dcount[dw]++;
        model_step();
        #1;
        chk("fetch_valid",   64'(fetch_valid),   64'(m_fv));
        chk("fetch_warp_id", 64'(fetch_warp_id), 64'(m_fid));
        chk("fetch_pc",      64'(fetch_pc),      64'(m_fpc));
        chk("credit_err",    64'(credit_err),    64'(m_err));
    endtask

    // Drive the oldest due decode response, if any (only while rdy is high).
    task automatic drive_resp();
        resp_valid   = 1'b0;
        resp_warp_id = 2'd0;
        if (!rdy) return;
        for (int j = 0; j < rq.size(); j++) begin
            if (rq[j].due <= cyc + 1) begin
                resp_valid   = 1'b1;
                resp_warp_id = 2'(rq[j].w);
                rq.delete(j);
                break;
            end
        end
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; warp_valid = '0; ibuf_release = '0;
        resp_valid = 1'b0; resp_warp_id = 2'd0; fetch_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rq.delete();
        for (int i = 0; i < N; i++) dcount[i] = 0;
    endtask

    initial begin
        rst = 1'b1;
        warp_pc = {32'h400, 32'h300, 32'h200, 32'h100};
        idle_inputs();
        resp_delay = 2;

        // Reset state
        do_reset();
        chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
        chk("rst_warp_id",     64'(fetch_warp_id), 64'd0);
        chk("rst_pc",          64'(fetch_pc), 64'd0);
        chk("rst_credit_err",  64'(credit_err), 64'd0);

        // All four warps, ready high, no responses: 0,1,2,3 then idle
        warp_valid = 4'b1111; fetch_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            tick();
            chk("rr_order_valid", 64'(fetch_valid), 64'd1);
            chk("rr_order_id",    64'(fetch_warp_id), 64'(i));
            chk("rr_order_pc",    64'(fetch_pc), 64'(32'h100 * (i + 1)));
        end
        tick();
        chk("all_inflight_idle", 64'(fetch_valid), 64'd0);

        // Warps 0 and 2 answered two cycles after grant: four grants each
        do_reset();
        resp_delay = 2;
        warp_valid = 4'b0101; fetch_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            drive_resp();
            tick();
        end
        chk("credit_grants_w0", 64'(dcount[0]), 64'd4);
        chk("credit_grants_w2", 64'(dcount[2]), 64'd4);
        chk("credit_grants_w1", 64'(dcount[1]), 64'd0);
        chk("credit_stall",     64'(fetch_valid), 64'd0);
        drive_resp();
        ibuf_release = 4'b0001;
        tick();
        ibuf_release = 4'b0000;
        for (int c = 0; c < 15; c++) begin
            drive_resp();
            tick();
        end
        chk("release_one_more", 64'(dcount[0]), 64'd5);
        chk("release_w2_none",  64'(dcount[2]), 64'd4);

        // Stalled request stays stable while PC and valid change
        do_reset();
        warp_valid = 4'b0010; warp_pc[1*PW +: PW] = 32'h80; fetch_ready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            warp_pc[1*PW +: PW] = 32'h90;
            warp_valid = 4'b0000;
            tick();
            chk("stall_valid", 64'(fetch_valid), 64'd1);
            chk("stall_id",    64'(fetch_warp_id), 64'd1);
            chk("stall_pc",    64'(fetch_pc), 64'h80);
        end
        chk("stall_no_grant", 64'(dcount[1]), 64'd0);
        fetch_ready = 1'b1;
        tick();
        chk("stall_grant", 64'(dcount[1]), 64'd1);
        warp_pc = {32'h400, 32'h300, 32'h200, 32'h100};

        // Release and grant together at full credits, then release at full
        do_reset();
        warp_valid = 4'b1000; fetch_ready = 1'b1;
        tick();
        ibuf_release = 4'b1000;
        tick();
        chk("grant_release_no_err", 64'(credit_err), 64'd0);
        tick();
        chk("full_release_err", 64'(credit_err), 64'd1);
        ibuf_release = 4'b0000;
        for (int c = 0; c < 3; c++) tick();
        chk("err_sticky", 64'(credit_err), 64'd1);

        // rdy low freezes state and drops response/release pulses
        do_reset();
        warp_valid = 4'b0001; fetch_ready = 1'b1;
        tick();
        tick();
        rdy = 1'b0; resp_valid = 1'b1; resp_warp_id = 2'd0; ibuf_release = 4'b0001;
        for (int c = 0; c < 3; c++) tick();
        rdy = 1'b1; resp_valid = 1'b0; ibuf_release = 4'b0000;
        for (int c = 0; c < 3; c++) tick();
        chk("rdy_low_inflight_kept", 64'(fetch_valid), 64'd0);
        chk("rdy_low_grants", 64'(dcount[0]), 64'd1);

        // Reset mid-request; first post-reset grant goes to lowest active warp
        do_reset();
        warp_valid = 4'b1111; fetch_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        tick();
        chk("midrst_valid", 64'(fetch_valid), 64'd0);
        rst = 1'b0; warp_valid = 4'b0110;
        tick();
        chk("post_rst_id", 64'(fetch_warp_id), 64'd1);
        chk("post_rst_pc", 64'(fetch_pc), 64'h200);

        // Randomized traffic
        do_reset();
        resp_delay = 0;
        warp_valid = 4'b1111;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            rdy = ($urandom_range(0, 6) != 0);
            if ($urandom_range(0, 9) == 0) warp_valid = 4'($urandom | $urandom);
            if ($urandom_range(0, 3) == 0) warp_pc = {$urandom, $urandom, $urandom, $urandom};
            fetch_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++)
                ibuf_release[i] = (m_cred[i] < D) ? ($urandom_range(0, 2) == 0)
                                                  : ($urandom_range(0, 39) == 0);
            drive_resp();
            if (!resp_valid && $urandom_range(0, 19) == 0) begin
                resp_valid   = 1'b1;
                resp_warp_id = 2'($urandom_range(0, N - 1));
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gelato_fetch_arbiter.md
# gelato_fetch_arbiter

Per-warp fetch arbiter that picks which warp's PC goes to the instruction-fetch stage each cycle. It sits between the split/PC table and the inst-fetch unit, next to the fetch scheduler. It shares the single fetch port round-robin among active warps, tracks instruction-buffer credits per warp, and allows at most one fetch in flight per warp until decode reports back.

## Interface
- NUM_WARPS, 4: warps sharing the fetch port (power of two, ≥2); WID = $clog2(NUM_WARPS).
- PC_WIDTH, 32: PC width.
- IBUF_DEPTH, 4: ibuffer entries per warp; credit counter width CW = $clog2(IBUF_DEPTH+1).

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; when 0, no state changes and all inputs are ignored.
- warp_valid  in  NUM_WARPS  warp i is active and its PC is valid.
- warp_pc  in  NUM_WARPS*PC_WIDTH  packed PCs; warp i occupies bits [i*PC_WIDTH +: PC_WIDTH].
- ibuf_release  in  NUM_WARPS  one-cycle pulse; one ibuffer entry of warp i has been dequeued.
- resp_valid  in  1  decode finished one fetched instruction.
- resp_warp_id  in  WID  warp of that response.
- fetch_valid  out  1  registered fetch request.
- fetch_ready  in  1  fetch unit accepts the request.
- fetch_warp_id  out  WID  requesting warp.
- fetch_pc  out  PC_WIDTH  PC to fetch.
- credit_err  out  1  sticky; set on any release while credits are already full.

## Operation
- Per-warp state:
  - credits[i] (0..IBUF_DEPTH)
  - inflight[i] (1 bit)
  - one round-robin pointer rr_ptr (WID bits)
- eligible[i] = warp_valid[i] & ~inflight[i] & (credits[i] != 0), computed from registered state. Exclude warp i if it is being granted this cycle.
- Grant = fetch_valid & fetch_ready & rdy, for warp g = fetch_warp_id. On grant:
  - inflight[g] is set.
  - credits[g] is decremented.
- Load condition: rdy & (~fetch_valid | fetch_ready). When it holds:
  - Search eligible[] starting at rr_ptr, upward with wraparound.
  - If a warp w is found: fetch_valid←1, fetch_warp_id←w, fetch_pc←warp_pc[w] (sampled at this edge), rr_ptr←w+1 mod NUM_WARPS.
  - If none is found: fetch_valid←0. fetch_warp_id, fetch_pc and rr_ptr hold.
- While fetch_valid=1 and fetch_ready=0, the request and pointer stay stable. This holds even if warp_valid for that warp drops; the request is not retracted.
- resp_valid with rdy clears inflight[resp_warp_id]. A response to a warp whose inflight is 0 is ignored.
- ibuf_release[i] with rdy increments credits[i]:
  - If credits[i]==IBUF_DEPTH, the count saturates and credit_err←1.
  - Release and grant on the same warp in the same cycle leave credits unchanged. No error is raised in that case, even at full.
- Multiple releases on different warps in one cycle are all applied.

## Timing
- Reset values:
  - fetch_valid=0, fetch_warp_id=0, fetch_pc=0, credit_err=0
  - credits[*]=IBUF_DEPTH, inflight[*]=0, rr_ptr=0
- Arbitration latency: a warp that becomes eligible in registered state at cycle t drives fetch_valid in cycle t+1.
- Back-to-back: a new request for a different warp can be loaded on the same edge as a grant. Throughput is 1 grant/cycle across warps.
- Per-warp turnaround: resp_valid sampled at edge t clears inflight, so the warp can be loaded at edge t+1 and fetch_valid is seen in cycle t+1→t+2. The same warp cannot be granted twice without an intervening response.
- Credits released at edge t are visible to arbitration from edge t+1.
- rst has priority over rdy and all other inputs. Reset mid-request drops fetch_valid the next cycle and discards inflight and credit state.
- rdy=0: outputs hold their values. A fetch_ready seen while rdy=0 is not a grant.

## Test plan
- Reset, warp_valid=4'b1111, PCs 0x100/0x200/0x300/0x400, fetch_ready=1, no responses → grants to warps 0,1,2,3 on consecutive cycles, then fetch_valid=0 (all inflight).
- Warps 0,2 active, each warp answered with resp_valid 2 cycles after its grant, no releases → each warp granted exactly IBUF_DEPTH=4 times, alternating 0,2,0,2…, then stalls at zero credits. A single ibuf_release[0] → exactly one more grant to warp 0.
- fetch_ready held low 5 cycles with warp 1 requested at PC 0x80, warp_pc[1] changed to 0x90 and warp_valid[1] dropped meanwhile → fetch_warp_id=1 and fetch_pc=0x80 stay stable. Grant occurs when ready rises.
- Same-cycle grant and ibuf_release on warp 3 with credits=4 → credits stay 4 and credit_err=0. A later release with credits=4 and no grant → credit_err=1, sticky until rst.
- rdy=0 for 3 cycles while resp_valid and ibuf_release pulse → no state change. Pulses are lost and inflight stays set.
- rst asserted while fetch_valid=1 and warp 2 inflight → next cycle fetch_valid=0, all credits=4, rr_ptr=0. First post-reset grant goes to the lowest active warp.
